// File: rtl/control_unit_pkg.sv
// Shared defines for the two-byte accumulator control unit:
// opcodes, ALU flag bits, FSM states and opcode classes.
package control_unit_pkg;

    localparam int OPC_W = 8;
    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_LOAD_I  = 8'h01;
    localparam opcode_t OP_LOAD_X  = 8'h02;
    localparam opcode_t OP_STORE_X = 8'h03;
    localparam opcode_t OP_ADD_I   = 8'h10;
    localparam opcode_t OP_ADD_X   = 8'h11;
    localparam opcode_t OP_SUB_I   = 8'h12;
    localparam opcode_t OP_SUB_X   = 8'h13;
    localparam opcode_t OP_AND_I   = 8'h14;
    localparam opcode_t OP_AND_X   = 8'h15;
    localparam opcode_t OP_OR_I    = 8'h16;
    localparam opcode_t OP_OR_X    = 8'h17;
    localparam opcode_t OP_XOR_I   = 8'h18;
    localparam opcode_t OP_XOR_X   = 8'h19;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_W = 4;

    typedef enum logic [2:0] {
        FETCH_OP  = 3'd0,
        DECODE    = 3'd1,
        FETCH_OPR = 3'd2,
        READ_MEM  = 3'd3,
        WRITE_MEM = 3'd4,
        EXEC      = 3'd5,
        ERROR     = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        CLS_NONE     = 2'd0,
        CLS_IMM      = 2'd1,
        CLS_MEM_READ = 2'd2,
        CLS_STORE    = 2'd3
    } op_class_e;

    function automatic op_class_e op_class(input opcode_t op);
        op_class_e cls;
        case (op)
            OP_LOAD_I, OP_ADD_I, OP_SUB_I,
            OP_AND_I, OP_OR_I, OP_XOR_I:
                cls = CLS_IMM;
            OP_LOAD_X, OP_ADD_X, OP_SUB_X,
            OP_AND_X, OP_OR_X, OP_XOR_X:
                cls = CLS_MEM_READ;
            OP_STORE_X:
                cls = CLS_STORE;
            default:
                cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/control_unit_op_decode.sv
// Combinational opcode classifier: one-hot class flags plus
// a valid bit for any defined opcode.
module op_decode
    import control_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] IR,
    output logic             valid,
    output logic             is_imm,
    output logic             is_mem_read,
    output logic             is_store
);

    op_class_e cls;

    always_comb begin
        cls         = op_class(IR[OPC_W-1:0]);
        is_imm      = 1'b0;
        is_mem_read = 1'b0;
        is_store    = 1'b0;
        unique case (1'b1)
            (cls == CLS_IMM):      is_imm      = 1'b1;
            (cls == CLS_MEM_READ): is_mem_read = 1'b1;
            (cls == CLS_STORE):    is_store    = 1'b1;
            default: ;
        endcase
        valid = is_imm | is_mem_read | is_store;
    end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for two-byte instructions with a
// req/ack memory port; every access state idles one cycle before req.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             run,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] AR,
    output logic             Exec,
    output logic [WIDTH-1:0] IR,
    output logic [WIDTH-1:0] IBR,
    output logic [WIDTH-1:0] MBR,
    output logic [WIDTH-1:0] PC,
    output logic             busy,
    output logic             error
);

    state_e           state_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] ir_q;
    logic [WIDTH-1:0] ibr_q;
    logic [WIDTH-1:0] mbr_q;
    logic [WIDTH-1:0] addr_q;
    logic             req_q;
    logic             we_q;
    logic             exec_q;

    logic op_valid;
    logic op_imm;
    logic op_mem_read;
    logic op_store;

    op_decode #(
        .WIDTH(WIDTH)
    ) u_dec (
        .IR         (ir_q),
        .valid      (op_valid),
        .is_imm     (op_imm),
        .is_mem_read(op_mem_read),
        .is_store   (op_store)
    );

    assign pc_d = pc_q + WIDTH'(1);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= FETCH_OP;
            pc_q    <= '0;
            ir_q    <= '0;
            ibr_q   <= '0;
            mbr_q   <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            exec_q  <= 1'b0;
        end else begin
            exec_q <= 1'b0;
            unique case (state_q)
                FETCH_OP: begin
                    if (req_q) begin
                        if (mem_ack) begin
                            ir_q    <= mem_rdata;
                            pc_q    <= pc_d;
                            req_q   <= 1'b0;
                            state_q <= DECODE;
                        end
                    end else if (run) begin
                        req_q  <= 1'b1;
                        we_q   <= 1'b0;
                        addr_q <= pc_q;
                    end
                end
                DECODE: begin
                    state_q <= op_valid ? FETCH_OPR : ERROR;
                end
                FETCH_OPR: begin
                    if (req_q) begin
                        if (mem_ack) begin
                            ibr_q <= mem_rdata;
                            pc_q  <= pc_d;
                            req_q <= 1'b0;
                            if (op_imm) begin
                                exec_q  <= 1'b1;
                                state_q <= EXEC;
                            end else if (op_store) begin
                                state_q <= WRITE_MEM;
                            end else begin
                                state_q <= READ_MEM;
                            end
                        end
                    end else begin
                        req_q  <= 1'b1;
                        we_q   <= 1'b0;
                        addr_q <= pc_q;
                    end
                end
                READ_MEM: begin
                    if (req_q) begin
                        if (mem_ack) begin
                            mbr_q   <= mem_rdata;
                            req_q   <= 1'b0;
                            exec_q  <= 1'b1;
                            state_q <= EXEC;
                        end
                    end else begin
                        req_q  <= 1'b1;
                        we_q   <= 1'b0;
                        addr_q <= ibr_q;
                    end
                end
                WRITE_MEM: begin
                    if (req_q) begin
                        if (mem_ack) begin
                            req_q   <= 1'b0;
                            we_q    <= 1'b0;
                            state_q <= FETCH_OP;
                        end
                    end else begin
                        req_q  <= 1'b1;
                        we_q   <= 1'b1;
                        addr_q <= ibr_q;
                    end
                end
                EXEC: begin
                    state_q <= FETCH_OP;
                end
                ERROR: begin
                    state_q <= ERROR;
                end
                default: begin
                    state_q <= ERROR;
                end
            endcase
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = AR;
    assign Exec      = exec_q;
    assign IR        = ir_q;
    assign IBR       = ibr_q;
    assign MBR       = mbr_q;
    assign PC        = pc_q;

    // Idle means parked in FETCH_OP without an outstanding request
    assign busy  = !((state_q == FETCH_OP) && !req_q) && (state_q != ERROR);
    assign error = (state_q == ERROR);

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter WIDTH, default 8: data, instruction and address width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 arst  input  1  reset, asynchronous, active-high.
REQ-004 run  input  1  level; a new instruction fetch starts only while high.
REQ-005 mem_req  output  1  memory request, held until mem_ack.
REQ-006 mem_we  output  1  write qualifier, valid with mem_req.
REQ-007 mem_addr  output  WIDTH  memory address, valid with mem_req.
REQ-008 mem_wdata  output  WIDTH  write data; always equals AR.
REQ-009 mem_rdata  input  WIDTH  read data, valid in the mem_ack cycle.
REQ-010 mem_ack  input  1  one-cycle completion strobe.
REQ-011 AR  input  WIDTH  accumulator from the ALU.
REQ-012 Exec  output  1  one-cycle ALU execute strobe.
REQ-013 IR, IBR, MBR  output  WIDTH each  instruction, immediate and memory buffer registers.
REQ-014 PC  output  WIDTH  program counter.
REQ-015 busy  output  1  high in every state except FETCH_OP idle and ERROR.
REQ-016 error  output  1  high while in ERROR.

Function
REQ-017 States SHALL be FETCH_OP, DECODE, FETCH_OPR, READ_MEM, WRITE_MEM, EXEC, ERROR.
REQ-018 Every instruction SHALL be two bytes: opcode at PC, operand at PC+1.
REQ-019 FETCH_OP: with run=1, assert mem_req, mem_we=0, mem_addr=PC; on mem_ack, IR<=mem_rdata, PC<=PC+1, go to DECODE; with run=0, hold with mem_req=0.
REQ-020 DECODE (one cycle): opcode in a defined class -> FETCH_OPR; otherwise -> ERROR.
REQ-021 FETCH_OPR: read at PC; on mem_ack, IBR<=mem_rdata, PC<=PC+1; then memory-operand ALU and LOAD_X -> READ_MEM, immediate ALU and LOAD_I -> EXEC, STORE_X -> WRITE_MEM.
REQ-022 READ_MEM: read at address IBR; on mem_ack, MBR<=mem_rdata, go to EXEC.
REQ-023 WRITE_MEM: mem_req=1, mem_we=1, mem_addr=IBR, mem_wdata=AR; on mem_ack -> FETCH_OP; Exec not asserted.
REQ-024 EXEC: Exec=1 for exactly one cycle, IR/IBR/MBR stable, then -> FETCH_OP.
REQ-025 mem_req SHALL deassert in the cycle after mem_ack; address and we SHALL be stable while mem_req is high.
REQ-026 mem_ack while mem_req=0 SHALL be ignored.
REQ-027 PC SHALL wrap modulo 2^WIDTH (all-ones + 1 -> 0).
REQ-028 ERROR SHALL be sticky: no memory requests, no Exec, registers frozen, until arst.
REQ-029 Minimum latency with zero-wait memory (ack one cycle after req): immediate instruction 6 cycles, memory-operand 8, store 7.
REQ-030 run deasserting mid-instruction SHALL NOT abort it; it takes effect at the next FETCH_OP.

Reset
REQ-031 arst SHALL force FETCH_OP, PC=0, IR=IBR=MBR=0, Exec=0, mem_req=0, mem_we=0, busy=0, error=0, immediately, including mid-transaction; a pending mem_ack after reset is ignored.

Structure
REQ-032 State encodings and opcode class constants SHALL reside in the shared defines file alongside the existing opcode and flag-bit defines.
REQ-033 Opcode classification SHALL be a combinational sub-module op_decode (IR in; valid, is_imm, is_mem_read, is_store out).

Verification
REQ-034 Reset, run=1, memory[0..1]=LOAD_I,0x5A, zero-wait -> reads at 0x00 then 0x01, IBR=0x5A, Exec pulses once in cycle 6, PC=0x02.
REQ-035 memory[0..1]=ADD_X,0x80, memory[0x80]=0x11 -> third read at 0x80, MBR=0x11 at Exec, PC=0x02.
REQ-036 STORE_X,0x40 with AR=0xC3 -> one write, mem_we=1, addr 0x40, wdata 0xC3, no Exec.
REQ-037 Opcode 0xFF (undefined) at 0x00 -> ERROR after DECODE, error=1, mem_req stays 0 for 20 cycles; arst clears error and PC=0.
REQ-038 PC=0xFF via instruction at 0xFE, ack delayed 3 cycles each access -> operand read at 0xFF, PC wraps to 0x00, mem_addr stable during waits.
REQ-039 arst asserted while READ_MEM waits for ack -> mem_req drops immediately; a late mem_ack is ignored; next fetch is at 0x00.
